// File: rtl/ctu_clsp_syncp_ctl_if.sv
// CSR-side programming/request bus and sync-pulse generator control outputs
// of the CMP-domain cluster sync-pulse sequencer.
interface ctu_clsp_syncp_ctl_if;
  logic       cfg_wr;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_wdata;
  logic       sync_start;
  logic       sync_commit;
  logic       sync_stop;
  logic       coin_cnt_ld;
  logic       coin_cnt_en;
  logic [4:0] clsp_sync_tx0;
  logic [4:0] clsp_sync_tx1;
  logic [4:0] clsp_sync_tx2;
  logic [1:0] clsp_sync_rx0;
  logic [1:0] clsp_sync_rx1;
  logic [1:0] clsp_sync_rx2;
  logic [4:0] clsp_sync_init;
  logic [4:0] clsp_sync_period;
  logic       sync_busy;
  logic       sync_running;
  logic       cfg_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, sync_start, sync_commit, sync_stop,
    input  coin_cnt_ld, coin_cnt_en, clsp_sync_tx0, clsp_sync_tx1, clsp_sync_tx2,
           clsp_sync_rx0, clsp_sync_rx1, clsp_sync_rx2, clsp_sync_init,
           clsp_sync_period, sync_busy, sync_running, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, sync_start, sync_commit, sync_stop,
    output coin_cnt_ld, coin_cnt_en, clsp_sync_tx0, clsp_sync_tx1, clsp_sync_tx2,
           clsp_sync_rx0, clsp_sync_rx1, clsp_sync_rx2, clsp_sync_init,
           clsp_sync_period, sync_busy, sync_running, cfg_err
  );
endinterface

// File: rtl/ctu_clsp_syncp_ctl.sv
// Cluster sync-pulse sequencer: staged/active config, mirrored period counter,
// boundary-aligned start/reprogram/stop. Optional CTU_CLSP_SYNCP_CHK_EN validates config.
module ctu_clsp_syncp_ctl #(
  parameter int DRAIN_CYC = 6
) (
  input logic              cmp_clk,
  input logic              cmp_rst,
  ctu_clsp_syncp_ctl_if.slave bus
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [4:0] tx0;
    logic [4:0] tx1;
    logic [4:0] tx2;
    logic [1:0] rx0;
    logic [1:0] rx1;
    logic [1:0] rx2;
    logic [4:0] init;
    logic [4:0] period;
  } cfg_t;

  state_e        state_q, state_d;
  cfg_t          stg_q, stg_d, act_q, act_d;
  logic [4:0]    mcnt_q, mcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          pend_commit_q, pend_commit_d, pend_stop_q, pend_stop_d;
  logic          ld_q, ld_d, en_q, en_d, busy_q, busy_d, run_q, run_d, err_q, err_d;
  logic          boundary, drain_done, stg_ok, reject;

  assign boundary   = (state_q == RUN) && (mcnt_q == 5'd0);
  assign drain_done = (dcnt_q == DW'(DRAIN_CYC - 1));

`ifdef CTU_CLSP_SYNCP_CHK_EN
  assign stg_ok = (stg_q.period != 5'd0) && (stg_q.init <= stg_q.period) &&
                  (stg_q.tx0 <= stg_q.period) && (stg_q.tx1 <= stg_q.period) &&
                  (stg_q.tx2 <= stg_q.period);
`else
  assign stg_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cmp_clk or posedge cmp_rst) begin
    if (cmp_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    reject  = 1'b0;
    case (state_q)
      IDLE: if (bus.sync_start) begin
        if (stg_ok) state_d = LOAD;
        else        reject  = 1'b1;
      end
      LOAD: state_d = RUN;
      RUN:  if (boundary && (pend_stop_q || pend_commit_q)) state_d = DRAIN;
      DRAIN: if (drain_done) begin
        if (pend_stop_q)  state_d = IDLE;
        else if (stg_ok)  state_d = LOAD;
        else begin
          state_d = RUN;
          reject  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stg_d = stg_q;
    if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        3'd0: stg_d.tx0    = bus.cfg_wdata;
        3'd1: stg_d.tx1    = bus.cfg_wdata;
        3'd2: stg_d.tx2    = bus.cfg_wdata;
        3'd3: stg_d.rx0    = bus.cfg_wdata[1:0];
        3'd4: stg_d.rx1    = bus.cfg_wdata[1:0];
        3'd5: stg_d.rx2    = bus.cfg_wdata[1:0];
        3'd6: stg_d.init   = bus.cfg_wdata;
        default: stg_d.period = bus.cfg_wdata;
      endcase
    end

    act_d = (state_d == LOAD) ? stg_q : act_q;

    // Loaded on entry to LOAD so the first boundary lands init cycles after ld.
    if (state_d == LOAD)      mcnt_d = stg_q.init;
    else if (mcnt_q != 5'd0)  mcnt_d = mcnt_q - 5'd1;
    else                      mcnt_d = act_q.period;

    dcnt_d = (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;

    pend_commit_d = pend_commit_q;
    pend_stop_d   = pend_stop_q;
    if (state_q == DRAIN && state_d != DRAIN) begin
      pend_commit_d = 1'b0;
      pend_stop_d   = 1'b0;
    end else if (state_q == RUN) begin
      pend_stop_d   = pend_stop_q | bus.sync_stop;
      pend_commit_d = pend_commit_q | (bus.sync_commit & ~bus.sync_stop);
    end
  end

  // Outputs decode the next state so they can be registered with no input-to-output path.
  always_comb begin
    ld_d   = (state_d == LOAD);
    en_d   = (state_d == RUN);
    run_d  = (state_d == RUN);
    busy_d = pend_commit_d | pend_stop_d | (state_d == LOAD) | (state_d == DRAIN);
    err_d  = err_q | reject;
  end

  always_ff @(posedge cmp_clk or posedge cmp_rst) begin
    if (cmp_rst) begin
      stg_q         <= '0;
      act_q         <= '0;
      mcnt_q        <= '0;
      dcnt_q        <= '0;
      pend_commit_q <= 1'b0;
      pend_stop_q   <= 1'b0;
      ld_q          <= 1'b0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      stg_q         <= stg_d;
      act_q         <= act_d;
      mcnt_q        <= mcnt_d;
      dcnt_q        <= dcnt_d;
      pend_commit_q <= pend_commit_d;
      pend_stop_q   <= pend_stop_d;
      ld_q          <= ld_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      run_q         <= run_d;
      err_q         <= err_d;
    end
  end

  assign bus.coin_cnt_ld      = ld_q;
  assign bus.coin_cnt_en      = en_q;
  assign bus.clsp_sync_tx0    = act_q.tx0;
  assign bus.clsp_sync_tx1    = act_q.tx1;
  assign bus.clsp_sync_tx2    = act_q.tx2;
  assign bus.clsp_sync_rx0    = act_q.rx0;
  assign bus.clsp_sync_rx1    = act_q.rx1;
  assign bus.clsp_sync_rx2    = act_q.rx2;
  assign bus.clsp_sync_init   = act_q.init;
  assign bus.clsp_sync_period = act_q.period;
  assign bus.sync_busy        = busy_q;
  assign bus.sync_running     = run_q;
  assign bus.cfg_err          = err_q;

endmodule

// File: tb/tb_ctu_clsp_syncp_ctl.sv
// Scoreboard bench for ctu_clsp_syncp_ctl: stimulus queues expected ld/run/drain/idle
// events with their cycle and active config; a negedge monitor pops and compares.
module tb_ctu_clsp_syncp_ctl;

  typedef struct packed {
    logic [4:0] tx0;
    logic [4:0] tx1;
    logic [4:0] tx2;
    logic [1:0] rx0;
    logic [1:0] rx1;
    logic [1:0] rx2;
    logic [4:0] init;
    logic [4:0] period;
  } cfg_t;

  typedef enum int {EV_LD = 0, EV_RUN = 1, EV_DRAIN = 2, EV_IDLE = 3} ev_e;

  typedef struct {
    ev_e  kind;
    int   cyc;
    cfg_t cfg;
  } exp_t;

  logic cmp_clk = 1'b0;
  logic cmp_rst = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t q[$];
  cfg_t stg, act;
  logic p_en = 1'b0, p_busy = 1'b0;

  ctu_clsp_syncp_ctl_if bus();

  ctu_clsp_syncp_ctl #(.DRAIN_CYC(6)) dut (
    .cmp_clk (cmp_clk),
    .cmp_rst (cmp_rst),
    .bus     (bus)
  );

  always #5 cmp_clk = ~cmp_clk;
  always @(posedge cmp_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic cfg_t dut_cfg();
    cfg_t r;
    r.tx0 = bus.clsp_sync_tx0;   r.tx1 = bus.clsp_sync_tx1;   r.tx2 = bus.clsp_sync_tx2;
    r.rx0 = bus.clsp_sync_rx0;   r.rx1 = bus.clsp_sync_rx1;   r.rx2 = bus.clsp_sync_rx2;
    r.init = bus.clsp_sync_init; r.period = bus.clsp_sync_period;
    return r;
  endfunction

  task automatic ev(input ev_e k);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", int'(k), cyc);
    end else begin
      e = q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_cycle", 32'(cyc), 32'(e.cyc));
      if (k == EV_LD || k == EV_DRAIN) check("event_active_cfg", 32'(dut_cfg()), 32'(e.cfg));
    end
  endtask

  // Monitor: one event per negedge, derived from registered outputs only.
  always @(negedge cmp_clk) begin
    if (!cmp_rst) begin
      if (bus.coin_cnt_ld)                       ev(EV_LD);
      else if (bus.coin_cnt_en && !p_en)         ev(EV_RUN);
      else if (!bus.coin_cnt_en && p_en)         ev(EV_DRAIN);
      else if (!bus.coin_cnt_en && !bus.sync_busy && p_busy) ev(EV_IDLE);
    end
    p_en   = bus.coin_cnt_en;
    p_busy = bus.sync_busy;
  end

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    case (a)
      3'd0: stg.tx0 = d;       3'd1: stg.tx1 = d;       3'd2: stg.tx2 = d;
      3'd3: stg.rx0 = d[1:0];  3'd4: stg.rx1 = d[1:0];  3'd5: stg.rx2 = d[1:0];
      3'd6: stg.init = d;      default: stg.period = d;
    endcase
    @(negedge cmp_clk);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic c, input logic p);
    bus.sync_start = s; bus.sync_commit = c; bus.sync_stop = p;
    @(negedge cmp_clk);
    bus.sync_start = 1'b0; bus.sync_commit = 1'b0; bus.sync_stop = 1'b0;
  endtask

  task automatic wait_q(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge cmp_clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  // First cycle >= after where the mirror hits zero, given the LOAD cycle and config.
  function automatic int first_boundary(input int l, input int init, input int per, input int after);
    int b = l + init;
    while (b < after) b += per + 1;
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ld"},   32'(bus.coin_cnt_ld),  32'd0);
    check({tag, "_en"},   32'(bus.coin_cnt_en),  32'd0);
    check({tag, "_busy"}, 32'(bus.sync_busy),    32'd0);
    check({tag, "_run"},  32'(bus.sync_running), 32'd0);
    check({tag, "_err"},  32'(bus.cfg_err),      32'd0);
    check({tag, "_cfg"},  32'(dut_cfg()),        32'd0);
  endtask

  initial begin
    int c, k, b, l;
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.sync_start = 1'b0; bus.sync_commit = 1'b0; bus.sync_stop = 1'b0;
    stg = '0; act = '0;
    repeat (2) @(negedge cmp_clk);
    #1 cmp_rst = 1'b0;
    @(negedge cmp_clk);
    check_all_zero("reset");

    wr(3'd0, 5'd3); wr(3'd1, 5'd7); wr(3'd2, 5'd11);
    wr(3'd3, 5'd1); wr(3'd4, 5'd2); wr(3'd5, 5'd3);
    wr(3'd6, 5'd4); wr(3'd7, 5'd15);
    check("staging_not_visible", 32'(dut_cfg()), 32'd0);

    // Start, with a staging write landing during the LOAD cycle.
    c = cyc; act = stg; l = c + 1;
    q.push_back('{EV_LD, c + 1, act});
    q.push_back('{EV_RUN, c + 2, act});
    pulse(1'b1, 1'b0, 1'b0);
    wr(3'd2, 5'd6);
    wait_q("start_events");
    check("load_write_not_active", 32'(bus.clsp_sync_tx2), 32'd11);
    check("start_running", 32'(bus.sync_running), 32'd1);

    // Reprogram period to 9 while running.
    wr(3'd7, 5'd9);
    check("period_before_commit", 32'(bus.clsp_sync_period), 32'd15);
    k = cyc;
    b = first_boundary(l, 4, 15, k + 1);
    q.push_back('{EV_DRAIN, b + 1, act});
    act = stg;
    q.push_back('{EV_LD, b + 7, act});
    q.push_back('{EV_RUN, b + 8, act});
    l = b + 7;
    pulse(1'b0, 1'b1, 1'b0);
    check("period_after_commit_pulse", 32'(bus.clsp_sync_period), 32'd15);
    wait_q("commit_events");
    check("commit_running", 32'(bus.sync_running), 32'd1);

    // Stop and commit together: stop wins, no reload.
    wr(3'd0, 5'd2);
    k = cyc;
    b = first_boundary(l, 4, 9, k + 1);
    q.push_back('{EV_DRAIN, b + 1, act});
    q.push_back('{EV_IDLE, b + 7, act});
    pulse(1'b0, 1'b1, 1'b1);
    wait_q("stop_events");
    repeat (20) @(negedge cmp_clk);
    check("stop_idle_run", 32'(bus.sync_running), 32'd0);
    check("stop_cfg_kept", 32'(dut_cfg()), 32'(act));

    // Commit and stop pulses in IDLE are ignored (monitor flags any event).
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (30) @(negedge cmp_clk);
    check("idle_ignore_busy", 32'(bus.sync_busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    c = cyc; act = stg;
    q.push_back('{EV_LD, c + 1, act});
    q.push_back('{EV_RUN, c + 2, act});
    pulse(1'b1, 1'b0, 1'b0);
    wait_q("restart_events");
    check("restart_tx0", 32'(bus.clsp_sync_tx0), 32'd2);
    repeat (7) @(negedge cmp_clk);
    #1 cmp_rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge cmp_clk);
    @(negedge cmp_clk);
    #1 cmp_rst = 1'b0;
    stg = '0; act = '0;
    @(negedge cmp_clk);
    check_all_zero("post_reset");

`ifdef CTU_CLSP_SYNCP_CHK_EN
    wr(3'd6, 5'd20); wr(3'd7, 5'd15);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge cmp_clk);
    check("chk_reject_err", 32'(bus.cfg_err), 32'd1);
    check("chk_reject_idle", 32'(bus.sync_running), 32'd0);
    check("chk_reject_busy", 32'(bus.sync_busy), 32'd0);
    wr(3'd6, 5'd4);
    c = cyc; act = stg;
    q.push_back('{EV_LD, c + 1, act});
    q.push_back('{EV_RUN, c + 2, act});
    pulse(1'b1, 1'b0, 1'b0);
    wait_q("chk_valid_events");
    check("chk_valid_running", 32'(bus.sync_running), 32'd1);
    check("chk_err_sticky", 32'(bus.cfg_err), 32'd1);
`else
    wr(3'd6, 5'd20); wr(3'd7, 5'd15);
    c = cyc; act = stg;
    q.push_back('{EV_LD, c + 1, act});
    q.push_back('{EV_RUN, c + 2, act});
    pulse(1'b1, 1'b0, 1'b0);
    wait_q("nochk_events");
    check("nochk_err_zero", 32'(bus.cfg_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
